my_sum_pipe: RTL
================

# my_sum_pipe

Pipelined, parametrised signed adder tree that sums `in_terms` signed samples per cycle with configurable tree radix, registered stages, a valid/enable pipeline and selectable wrap or saturate output conversion. It is the registered successor to the combinational summing block. It targets the emulator datapaths where wide channel sums (FFE taps, pulse-response superposition) must close timing at full emulation clock rate. Overflow is reported per result and as a sticky status bit for the host.

## Interface
- `in_bits`, 8: width of each signed input term.
- `in_terms`, 8: number of input terms (>=1).
- `out_bits`, 8: width of signed output.
- `radix`, 2: terms summed per tree node per stage (2..4).
- `saturate`, 0: 0 = wrap (keep LSBs), 1 = clamp to out_bits signed range.

- `clk`  in  1  clock, all state on rising edge.
- `rst_n`  in  1  reset, asynchronous assert, active-low.
- `en`  in  1  pipeline advance; low holds every stage.
- `in_valid`  in  1  qualifies `in` this cycle.
- `in`  in  [in_bits-1:0] x in_terms  signed unpacked array of terms.
- `clr_sticky`  in  1  clears `ovf_sticky`.
- `out_valid`  out  1  `out`/`ovf` hold a new result (meaningful when `en`=1).
- `out`  out  signed [out_bits-1:0]  sum.
- `ovf`  out  1  this result exceeded out_bits range.
- `ovf_sticky`  out  1  any overflow since reset or last clear.

## Operation
- Internal width W = in_bits + ceil(log2(in_terms)); all tree arithmetic is sign-extended to W, full precision, never overflows internally.
- Stage count L = max(1, ceil(log_radix(in_terms))). Stage k sums groups of up to `radix` partial sums from stage k-1. A short final group passes through with fewer addends. Every stage is registered.
- Output conversion is in the last stage's register path. If W <= out_bits: sign-extend, `ovf`=0. Otherwise test the full sum S against [-2^(out_bits-1), 2^(out_bits-1)-1]. Out of range: `ovf`=1; `out` = clamped bound (saturate=1) or S[out_bits-1:0] (saturate=0).
- Valid: a 1-bit shift register of depth L tracks `in_valid` alongside data. `out_valid` is its last bit. Data of invalid slots is still summed (don't-care); `ovf` is forced 0 when `out_valid`=0.
- `ovf_sticky`: set on any cycle with `en`=1, `out_valid` next-state 1 and `ovf` next-state 1. Cleared by `clr_sticky`=1. Simultaneous set and clear: set wins.
- No state machine beyond the stage/valid registers; no backpressure other than `en`.

## Timing
- Reset values: all stage registers 0, `out`=0, `out_valid`=0, `ovf`=0, `ovf_sticky`=0.
- Latency L cycles of `en`=1: inputs sampled at edge n appear at `out` after edge n+L-1 (visible in cycle n+L). Throughput one sum per enabled cycle.
- `en`=0: all data, valid and `ovf` registers hold; `ovf_sticky` may still be cleared by `clr_sticky`; `in` ignored.
- `rst_n` low mid-stream: immediately clears everything, all in-flight sums discarded. The first `out_valid` after release is L enabled cycles after the first sampled `in_valid`.
- in_terms=1: L=1, pure registered pass-through with conversion.

## Test plan
Config for scenarios 1-5: in_bits=8, in_terms=8, out_bits=8, radix=2, so L=3 and W=11.
- Single beat, all terms +1, `in_valid`=1 -> `out`=8, `out_valid`=1 exactly 3 cycles later, one cycle wide, `ovf`=0.
- saturate=1, all terms 127 -> `out`=127, `ovf`=1, `ovf_sticky`=1. Next beat all -128 -> `out`=-128, `ovf`=1. Next beat mixed summing to -5 -> `out`=-5, `ovf`=0, sticky stays 1.
- saturate=0, all terms 127 (S=1016=0x3F8) -> `out`=-8 (0xF8), `ovf`=1.
- Back-to-back beats 1..6 (all terms = beat index), `en` low 2 cycles after beat 3 -> outputs 8,16,24,32,40,48 in order, none lost or duplicated, output held during stall.
- `rst_n` pulsed low with 2 beats in flight -> `out`/`out_valid`/`ovf`/`ovf_sticky` go 0 without a clock edge, and no stale result emerges after release.
- `clr_sticky`=1 in the same cycle an overflowing result registers -> `ovf_sticky` stays 1. `clr_sticky` alone afterwards -> 0. Repeat with radix=3, in_terms=5 (L=2) -> sum 5x100 with out_bits=12 gives `out`=500 after 2 cycles.

Source files
------------

// File: rtl/my_sum_pipe.sv
// my_sum_pipe: pipelined signed adder tree with a configurable radix and one register per tree level.
// The final level also converts the full-precision sum to out_bits, either by wrapping or by saturating.
// A valid bit travels alongside the data. Overflow is flagged on each result and collected into a sticky bit.
module my_sum_pipe #(
    parameter int in_bits  = 8,
    parameter int in_terms = 8,
    parameter int out_bits = 8,
    parameter int radix    = 2,
    parameter int saturate = 0
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       en,
    input  logic                       in_valid,
    input  logic signed [in_bits-1:0]  in [in_terms],
    input  logic                       clr_sticky,
    output logic                       out_valid,
    output logic signed [out_bits-1:0] out,
    output logic                       ovf,
    output logic                       ovf_sticky
);

    // Number of nodes present after a given number of reduction levels.
    function automatic int nodesAt(input int level);
        int n;
        n = in_terms;
        for (int s = 0; s < level; s++) begin
            n = (n + radix - 1) / radix;
        end
        return n;
    endfunction

    // Number of levels needed to reduce in_terms down to one node.
    // There is always at least one level, so a single term still gets registered.
    function automatic int stageCount();
        int n;
        int s;
        n = in_terms;
        s = 0;
        while (n > 1) begin
            n = (n + radix - 1) / radix;
            s++;
        end
        return (s < 1) ? 1 : s;
    endfunction

    // This width holds the sum of every term at full precision, so no level can overflow internally.
    localparam int W = in_bits + $clog2(in_terms);
    localparam int L = stageCount();

    logic signed [W-1:0]        total;
    logic signed [out_bits-1:0] out_d;
    logic                       convOvf;
    logic [L-1:0]               valid_d;
    logic                       ovf_d;

    logic signed [out_bits-1:0] out_q;
    logic                       ovf_q;
    logic [L-1:0]               valid_q;
    logic                       sticky_q;

    // Tree levels.
    // Each level pads its input list with zeros up to a whole number of groups.
    // Because of that padding, a short final group needs no special handling.
    // Every level except the last registers its partial sums.
    // The last level's single sum goes straight into the output conversion.
    for (genvar k = 0; k < L; k++) begin : g_stage
        localparam int NIN  = nodesAt(k);
        localparam int NOUT = nodesAt(k + 1);
        localparam int NPAD = NOUT * radix;

        logic signed [W-1:0] src [NPAD];
        logic signed [W-1:0] partial_d [NOUT];

        for (genvar i = 0; i < NPAD; i++) begin : g_src
            if (i >= NIN) begin : g_pad
                assign src[i] = '0;
            end else if (k == 0) begin : g_input
                assign src[i] = W'(in[i]);
            end else begin : g_prev
                assign src[i] = g_stage[k-1].g_reg.partial_q[i];
            end
        end

        // Reduce each group of radix entries to one partial sum
        always_comb begin
            for (int j = 0; j < NOUT; j++) begin
                partial_d[j] = '0;
                for (int t = 0; t < radix; t++) begin
                    partial_d[j] = partial_d[j] + src[j*radix + t];
                end
            end
        end

        if (k < L - 1) begin : g_reg
            logic signed [W-1:0] partial_q [NOUT];

            // Capture this level's partial sums; hold them while the pipeline is stalled
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    for (int j = 0; j < NOUT; j++) begin
                        partial_q[j] <= '0;
                    end
                end else if (en) begin
                    partial_q <= partial_d;
                end
            end
        end
    end

    assign total = g_stage[L-1].partial_d[0];

    // Output conversion.
    // If the full-precision sum already fits in out_bits, it is only sign-extended.
    // Otherwise the bits from out_bits-1 upward must all be equal for the value to be in range.
    if (W <= out_bits) begin : g_extend
        assign out_d   = out_bits'(total);
        assign convOvf = 1'b0;
    end else begin : g_narrow
        logic [W-out_bits:0] head;
        logic                fits;

        assign head = total[W-1:out_bits-1];
        assign fits = (&head) | ~(|head);

        // Pick the wrapped low bits, or the clamped bound when saturation is enabled
        always_comb begin
            out_d   = total[out_bits-1:0];
            convOvf = 1'b0;
            if (!fits) begin
                convOvf = 1'b1;
                if (saturate != 0) begin
                    out_d = total[W-1] ? {1'b1, {(out_bits-1){1'b0}}}
                                       : {1'b0, {(out_bits-1){1'b1}}};
                end
            end
        end
    end

    // The valid shift register moves in step with the data levels.
    // Only slots that carry a valid result may report an overflow.
    assign valid_d = L'({valid_q, in_valid});
    assign ovf_d   = convOvf & valid_d[L-1];

    // Register the converted result, its overflow flag and the valid chain
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_q   <= '0;
            ovf_q   <= 1'b0;
            valid_q <= '0;
        end else if (en) begin
            out_q   <= out_d;
            ovf_q   <= ovf_d;
            valid_q <= valid_d;
        end
    end

    // Sticky overflow for the host: a new overflow takes priority over a clear arriving in the same cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sticky_q <= 1'b0;
        end else if (en && ovf_d) begin
            sticky_q <= 1'b1;
        end else if (clr_sticky) begin
            sticky_q <= 1'b0;
        end
    end

    assign out        = out_q;
    assign ovf        = ovf_q;
    assign out_valid  = valid_q[L-1];
    assign ovf_sticky = sticky_q;

endmodule
